vend_session_arbiter: RTL and testbench
=======================================

Name: vend_session_arbiter

Overview:
Round-robin arbiter and sequencer that shares one VendingMachine core between two requesters (front-panel kiosk = 0, online/app kiosk = 1). It latches the granted requester's order and drives the core's start, product, payment and coin inputs. It then waits for dispense or timeout, cancelling on timeout, and returns a one-cycle result to the owning requester.

Parameters:
START_CYCLES, 3, cycles o_vm_start is held high per session (min 1)
TIMEOUT_CYCLES, 16, max cycles in WAIT before forced cancel (min 1)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_req  in  2  per-requester request level; bit n = requester n
i_cancel  in  2  per-requester abort; honoured only for the granted requester
i_product_code0 / i_product_code1  in  3  product selection
i_online_payment0 / i_online_payment1  in  1  online payment flag
i_coin_value0 / i_coin_value1  in  7  total coin value
i_vm_dispense  in  1  core dispense indication
i_vm_return_change  in  7  core change value
i_vm_product_price  in  7  core price value
o_vm_start  out  1  core start
o_vm_cancel  out  1  core cancel
o_vm_product_code  out  3  latched product
o_vm_online_payment  out  1  latched payment flag
o_vm_coin_value  out  7  latched coin value
o_grant  out  2  one-hot owner; 0 when IDLE
o_done  out  2  one-cycle completion pulse to the owner
o_result_ok  out  1  1 = dispensed; valid with o_done
o_result_change  out  7  change or refund; valid with o_done
o_result_price  out  7  price captured at dispense; 0 on cancel
o_busy  out  1  state != IDLE
o_state  out  3  IDLE=0, START=1, WAIT=2, CANCEL=3, DONE=4

Behaviour:
- Reset: all outputs 0, state IDLE, internal last-served pointer = 1, so requester 0 wins the first contention. Reset in any state aborts the session with no o_done. o_vm_start and o_vm_cancel drop on the reset edge.
- IDLE: on the edge where any i_req bit is 1, pick the winner. If only one bit is set, that requester wins. If both are set, the requester != last-served wins. Latch the winner's product code, payment flag and coin value into o_vm_*. Set o_grant, update last-served, load counter = 0, go to START.
- START: o_vm_start = 1 for exactly START_CYCLES cycles, then WAIT with counter = 0.
- WAIT: o_vm_start = 0. Counter increments each cycle. When counter == TIMEOUT_CYCLES-1 with no dispense, go to CANCEL.
- i_vm_dispense = 1 while in START or WAIT: capture change and price, set ok = 1, go to DONE next edge. This drops o_vm_start early if the dispense arrives during START.
- i_cancel[owner] = 1 in START or WAIT with no dispense on the same cycle: go to CANCEL. Dispense has priority over both cancel and timeout on the same cycle.
- i_cancel for the non-owner is ignored.
- CANCEL: o_vm_cancel = 1 for exactly one cycle. Set ok = 0, change = latched coin value (full refund), price = 0. Go to DONE.
- DONE: o_done[owner] = 1 and result outputs valid for one cycle. Next edge: IDLE, o_grant = 0.
- Result outputs hold their last value until the next DONE.
- Payload is latched only at grant; requester inputs changing mid-session have no effect.
- i_req dropping mid-session does not abort the session; the result is still delivered.
- A requester still asserting i_req in the DONE cycle is eligible again from IDLE. Minimum gap between sessions is 1 IDLE cycle.
- o_vm_* payload registers hold their value after the session until the next grant.

Test Plan:
- Single order: i_req = 01, product 001, coins 60; i_vm_dispense with change 20, price 40 on WAIT cycle 4 -> o_vm_start high 3 cycles; o_done = 01, ok = 1, change = 20, price = 40; o_state returns to 0.
- Contention after reset: i_req = 11 held -> requester 0 served first, then requester 1 (o_grant 01 then 10). With i_req still 11, the next session grants 01 again (alternation).
- Timeout: no dispense, coins 30 -> after START_CYCLES + 16 cycles, o_vm_cancel pulses for 1 cycle; o_done asserts with ok = 0, change = 30, price = 0.
- Owner cancel in WAIT cycle 2 -> CANCEL then DONE, refund equals the latched coins. A non-owner i_cancel pulse in the same session has no effect.
- Dispense coincident with the timeout cycle and with i_cancel[owner] -> ok = 1 and no o_vm_cancel pulse. Dispense during START cycle 2 -> o_vm_start drops and DONE follows.
- i_rst asserted mid-WAIT -> next cycle all outputs 0, no o_done. Then i_req = 11 -> requester 0 is granted.

Source files
------------

// File: rtl/vend_session_arbiter.sv
// Round-robin session arbiter in front of a single VendingMachine core.
// Two requesters (0 = front-panel kiosk, 1 = online/app kiosk) compete for
// the core. The winner's order is latched at grant, the core is started,
// and the session ends on dispense, owner cancel or timeout. The owner then
// receives a one-cycle o_done pulse with the result.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req[1:0]            request level per requester
//   i_cancel[1:0]         abort per requester (only the owner's bit counts)
//   i_product_code0/1     product selection per requester
//   i_online_payment0/1   online payment flag per requester
//   i_coin_value0/1       inserted coin total per requester
//   i_vm_dispense         core dispense indication
//   i_vm_return_change    core change value
//   i_vm_product_price    core price value
//   o_vm_start/o_vm_cancel              core control strobes
//   o_vm_product_code/online_payment/coin_value   latched order payload
//   o_grant[1:0]          one-hot owner, 0 when idle
//   o_done[1:0]           one-cycle completion pulse to the owner
//   o_result_ok/change/price   session result, valid with o_done
//   o_busy, o_state       session status
module vend_session_arbiter #(
    parameter int unsigned START_CYCLES   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic [1:0] i_cancel,
    input  logic [2:0] i_product_code0,
    input  logic [2:0] i_product_code1,
    input  logic       i_online_payment0,
    input  logic       i_online_payment1,
    input  logic [6:0] i_coin_value0,
    input  logic [6:0] i_coin_value1,
    input  logic       i_vm_dispense,
    input  logic [6:0] i_vm_return_change,
    input  logic [6:0] i_vm_product_price,
    output logic       o_vm_start,
    output logic       o_vm_cancel,
    output logic [2:0] o_vm_product_code,
    output logic       o_vm_online_payment,
    output logic [6:0] o_vm_coin_value,
    output logic [1:0] o_grant,
    output logic [1:0] o_done,
    output logic       o_result_ok,
    output logic [6:0] o_result_change,
    output logic [6:0] o_result_price,
    output logic       o_busy,
    output logic [2:0] o_state
);

    localparam int unsigned CNT_MAX = (START_CYCLES > TIMEOUT_CYCLES) ? START_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CANCEL = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               last, last_nxt;
    logic [1:0]         grant, grant_nxt;
    logic [2:0]         prod, prod_nxt;
    logic               pay, pay_nxt;
    logic [6:0]         coin, coin_nxt;
    logic               start, start_nxt;
    logic               cancel, cancel_nxt;
    logic [1:0]         done, done_nxt;
    logic               res_ok, res_ok_nxt;
    logic [6:0]         res_chg, res_chg_nxt;
    logic [6:0]         res_prc, res_prc_nxt;
    logic               busy, busy_nxt;
    logic               win1;
    logic               owner_cancel;

    // State and output registers; every output is a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            grant   <= 2'b00;
            prod    <= 3'd0;
            pay     <= 1'b0;
            coin    <= 7'd0;
            start   <= 1'b0;
            cancel  <= 1'b0;
            done    <= 2'b00;
            res_ok  <= 1'b0;
            res_chg <= 7'd0;
            res_prc <= 7'd0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            grant   <= grant_nxt;
            prod    <= prod_nxt;
            pay     <= pay_nxt;
            coin    <= coin_nxt;
            start   <= start_nxt;
            cancel  <= cancel_nxt;
            done    <= done_nxt;
            res_ok  <= res_ok_nxt;
            res_chg <= res_chg_nxt;
            res_prc <= res_prc_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next-state and next-output logic. Strobes (start/cancel/done) are
    // computed for the state being entered so they are high in that state.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_nxt     = last;
        grant_nxt    = grant;
        prod_nxt     = prod;
        pay_nxt      = pay;
        coin_nxt     = coin;
        start_nxt    = 1'b0;
        cancel_nxt   = 1'b0;
        done_nxt     = 2'b00;
        res_ok_nxt   = res_ok;
        res_chg_nxt  = res_chg;
        res_prc_nxt  = res_prc;
        // With both requesting, the one not served last wins.
        win1         = i_req[1] & (~i_req[0] | ~last);
        owner_cancel = |(i_cancel & grant);

        case (state)
            ST_IDLE: begin
                if (|i_req) begin
                    state_nxt = ST_START;
                    cnt_nxt   = '0;
                    last_nxt  = win1;
                    grant_nxt = win1 ? 2'b10 : 2'b01;
                    prod_nxt  = win1 ? i_product_code1   : i_product_code0;
                    pay_nxt   = win1 ? i_online_payment1 : i_online_payment0;
                    coin_nxt  = win1 ? i_coin_value1     : i_coin_value0;
                    start_nxt = 1'b1;
                end
            end
            ST_START: begin
                if (i_vm_dispense) begin
                    state_nxt   = ST_DONE;
                    done_nxt    = grant;
                    res_ok_nxt  = 1'b1;
                    res_chg_nxt = i_vm_return_change;
                    res_prc_nxt = i_vm_product_price;
                end else if (owner_cancel) begin
                    state_nxt  = ST_CANCEL;
                    cancel_nxt = 1'b1;
                end else if (cnt == CNT_W'(START_CYCLES - 1)) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    start_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_vm_dispense) begin
                    state_nxt   = ST_DONE;
                    done_nxt    = grant;
                    res_ok_nxt  = 1'b1;
                    res_chg_nxt = i_vm_return_change;
                    res_prc_nxt = i_vm_product_price;
                end else if (owner_cancel || (cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    state_nxt  = ST_CANCEL;
                    cancel_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_CANCEL: begin
                // Full refund of the latched coins.
                state_nxt   = ST_DONE;
                done_nxt    = grant;
                res_ok_nxt  = 1'b0;
                res_chg_nxt = coin;
                res_prc_nxt = 7'd0;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                grant_nxt = 2'b00;
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = 2'b00;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign o_vm_start          = start;
    assign o_vm_cancel         = cancel;
    assign o_vm_product_code   = prod;
    assign o_vm_online_payment = pay;
    assign o_vm_coin_value     = coin;
    assign o_grant             = grant;
    assign o_done              = done;
    assign o_result_ok         = res_ok;
    assign o_result_change     = res_chg;
    assign o_result_price      = res_prc;
    assign o_busy              = busy;
    assign o_state             = state;

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Randomised scoreboard bench for vend_session_arbiter. The driver plans
// each session (requests, dispense time, cancel time, optional reset),
// predicts its outcome from the arbitration/session rules and queues it;
// the monitor pops and compares whenever o_done fires.
module tb_vend_session_arbiter;

    localparam int S     = 3;
    localparam int T     = 16;
    localparam int NEVER = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, cancel;
    logic [2:0] pc0, pc1;
    logic       op0, op1;
    logic [6:0] cv0, cv1;
    logic       disp;
    logic [6:0] vchg, vprc;
    logic       vm_start, vm_cancel, vm_pay, res_ok, busy;
    logic [2:0] vm_prod, state;
    logic [6:0] vm_coin, res_chg, res_prc;
    logic [1:0] grant, done;

    vend_session_arbiter #(.START_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_cancel(cancel),
        .i_product_code0(pc0), .i_product_code1(pc1),
        .i_online_payment0(op0), .i_online_payment1(op1),
        .i_coin_value0(cv0), .i_coin_value1(cv1),
        .i_vm_dispense(disp), .i_vm_return_change(vchg), .i_vm_product_price(vprc),
        .o_vm_start(vm_start), .o_vm_cancel(vm_cancel),
        .o_vm_product_code(vm_prod), .o_vm_online_payment(vm_pay), .o_vm_coin_value(vm_coin),
        .o_grant(grant), .o_done(done), .o_result_ok(res_ok),
        .o_result_change(res_chg), .o_result_price(res_prc),
        .o_busy(busy), .o_state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] grant;
        logic [2:0] prod;
        logic       pay;
        logic [6:0] coin;
        logic       ok;
        logic [6:0] chg;
        logic [6:0] prc;
        int         starts;
        int         cancels;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [1:0] req;
        int         d;
        int         c;
        bit         do_rst;
    } plan_t;

    exp_t  sb[$];
    plan_t plans[$];
    int    checks = 0;
    int    errors = 0;
    int    last_served;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"},  int'(state), 0);
        chk({tag, "_grant"},  int'(grant), 0);
        chk({tag, "_done"},   int'(done), 0);
        chk({tag, "_start"},  int'(vm_start), 0);
        chk({tag, "_cancel"}, int'(vm_cancel), 0);
        chk({tag, "_busy"},   int'(busy), 0);
        chk({tag, "_payload"}, int'({vm_prod, vm_pay, vm_coin}), 0);
        chk({tag, "_result"}, int'({res_ok, res_chg, res_prc}), 0);
    endtask

    // Monitor: tracks session-relative cycle count and strobe counts.
    initial begin
        logic [1:0] prev_grant = 2'b00;
        int cyc = 0, nstart = 0, ncan = 0;
        bit post_done = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_grant = 2'b00;
                post_done  = 0;
                continue;
            end
            if (post_done) begin
                chk("done_width", int'(done), 0);
                chk("idle_after_done", int'(state), 0);
                post_done = 0;
            end
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                cyc = 0; nstart = int'(vm_start); ncan = int'(vm_cancel);
            end else if (grant != 2'b00) begin
                cyc++; nstart += int'(vm_start); ncan += int'(vm_cancel);
            end
            prev_grant = grant;
            if (done != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=%0d expected=none", done);
                end else begin
                    e = sb.pop_front();
                    chk("done",     int'(done), int'(e.grant));
                    chk("grant",    int'(grant), int'(e.grant));
                    chk("state",    int'(state), 4);
                    chk("busy",     int'(busy), 1);
                    chk("ok",       int'(res_ok), int'(e.ok));
                    chk("change",   int'(res_chg), int'(e.chg));
                    chk("price",    int'(res_prc), int'(e.prc));
                    chk("prod",     int'(vm_prod), int'(e.prod));
                    chk("pay",      int'(vm_pay), int'(e.pay));
                    chk("coin",     int'(vm_coin), int'(e.coin));
                    chk("start_cycles",  nstart, e.starts);
                    chk("cancel_pulses", ncan, e.cancels);
                    chk("latency",  cyc, e.cyc);
                end
                post_done = 1;
            end
        end
    end

    task automatic run_session(input plan_t p);
        exp_t e;
        int   win, dd, cc, ev, gwait;
        logic [6:0] dchg, dprc;
        bit   got;
        pc0 = 3'($urandom_range(0, 7)); pc1 = 3'($urandom_range(0, 7));
        op0 = 1'($urandom_range(0, 1)); op1 = 1'($urandom_range(0, 1));
        cv0 = 7'($urandom_range(0, 127)); cv1 = 7'($urandom_range(0, 127));
        dchg = 7'($urandom_range(0, 127)); dprc = 7'($urandom_range(0, 127));

        // Reference: round-robin winner and session outcome.
        if (p.req == 2'b11) win = 1 - last_served;
        else win = p.req[1] ? 1 : 0;
        last_served = win;
        dd = (p.d < S + T) ? p.d : NEVER;
        cc = (p.c < S + T) ? p.c : NEVER;
        e.grant = (win == 1) ? 2'b10 : 2'b01;
        e.prod  = win ? pc1 : pc0;
        e.pay   = win ? op1 : op0;
        e.coin  = win ? cv1 : cv0;
        if (dd != NEVER && dd <= cc) begin
            ev = dd; e.ok = 1'b1; e.chg = dchg; e.prc = dprc;
            e.cancels = 0; e.cyc = dd + 1;
        end else begin
            ev = (cc < S + T - 1) ? cc : S + T - 1;
            e.ok = 1'b0; e.chg = e.coin; e.prc = 7'd0;
            e.cancels = 1; e.cyc = ev + 2;
        end
        e.starts = (ev + 1 < S) ? ev + 1 : S;
        if (!p.do_rst) sb.push_back(e);

        req = p.req;
        got = 0;
        for (gwait = 0; gwait < 8 && !got; gwait++) begin
            @(negedge clk);
            if (grant != 2'b00) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL grant_timeout actual=%0d expected=%0d", grant, e.grant);
            req = 2'b00;
            return;
        end
        // Requests and payload change mid-session; neither may matter.
        req = 2'b00;
        pc0 = 3'($urandom_range(0, 7)); pc1 = 3'($urandom_range(0, 7));
        cv0 = 7'($urandom_range(0, 127)); cv1 = 7'($urandom_range(0, 127));
        op0 = ~op0; op1 = ~op1;

        for (int t = 0; t < S + T + 2; t++) begin
            if (state == 3'd4 || state == 3'd0) break;
            if (p.do_rst && t == S + 2) begin
                rst = 1'b1; disp = 1'b0; cancel = 2'b00;
                @(negedge clk);
                chk_all_zero("mid_reset");
                rst = 1'b0;
                last_served = 1;
                return;
            end
            disp   = (t == p.d);
            vchg   = (t == p.d) ? dchg : 7'($urandom_range(0, 127));
            vprc   = (t == p.d) ? dprc : 7'($urandom_range(0, 127));
            cancel = 2'b00;
            if (t == p.c) cancel[win] = 1'b1;
            if ($urandom_range(0, 3) == 0) cancel[1 - win] = 1'b1;
            @(negedge clk);
        end
        disp = 1'b0; cancel = 2'b00;
        got = 0;
        for (gwait = 0; gwait < 40 && !got; gwait++) begin
            if (busy == 1'b0) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL session_end_timeout actual=%0d expected=0", state);
        end
        if ($urandom_range(0, 1) == 1) @(negedge clk);
    endtask

    initial begin
        plan_t p;
        rst = 1'b1; req = 2'b00; cancel = 2'b00; disp = 1'b0;
        pc0 = '0; pc1 = '0; op0 = 1'b0; op1 = 1'b0; cv0 = '0; cv1 = '0;
        vchg = '0; vprc = '0;
        last_served = 1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios.
        plans.push_back('{2'b11, 5, NEVER, 0});          // contention: 0 first
        plans.push_back('{2'b11, S + 1, NEVER, 0});      // then 1
        plans.push_back('{2'b11, S + 4, NEVER, 0});      // alternation back to 0
        plans.push_back('{2'b01, S + 4, NEVER, 0});      // single order, WAIT cycle 4
        plans.push_back('{2'b10, NEVER, NEVER, 0});      // timeout
        plans.push_back('{2'b01, NEVER, S + 2, 0});      // owner cancel in WAIT
        plans.push_back('{2'b10, S + T - 1, S + T - 1, 0}); // dispense on timeout + cancel
        plans.push_back('{2'b01, 1, NEVER, 0});          // dispense in START
        plans.push_back('{2'b10, NEVER, 0, 0});          // cancel in first START cycle
        plans.push_back('{2'b01, NEVER, NEVER, 1});      // reset mid-WAIT
        plans.push_back('{2'b11, 2, NEVER, 0});          // pointer back to reset value
        for (int i = 0; i < 60; i++) begin
            p.req = 2'($urandom_range(1, 3));
            p.d = NEVER; p.c = NEVER; p.do_rst = 0;
            case ($urandom_range(0, 4))
                0: p.d = $urandom_range(0, S + T - 1);
                1: p.c = $urandom_range(0, S + T - 1);
                2: begin
                    p.d = $urandom_range(0, S + T + 2);
                    p.c = $urandom_range(0, S + T + 2);
                end
                3: ;
                default: p.do_rst = ($urandom_range(0, 2) == 0);
            endcase
            plans.push_back(p);
        end

        foreach (plans[i]) run_session(plans[i]);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
